// File: rtl/keypad_loader_if.sv
// Keypad-side and timer-side signal bundle for keypad_loader.
// The master drives the keypad inputs; the slave (the loader) drives everything toward the timer and display.
interface keypad_loader_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] data;
  logic       loadn;
  logic       timer_clrn;
  logic       start;
  logic       error;
  logic       busy;
  logic [3:0] entry_mins;
  logic [3:0] entry_tens;
  logic [3:0] entry_ones;
  logic [1:0] digit_count;

  modport master (
    output key_code, key_valid,
    input  data, loadn, timer_clrn, start, error, busy,
    input  entry_mins, entry_tens, entry_ones, digit_count
  );

  modport slave (
    input  key_code, key_valid,
    output data, loadn, timer_clrn, start, error, busy,
    output entry_mins, entry_tens, entry_ones, digit_count
  );
endinterface

// File: rtl/keypad_loader.sv
// Keypad front end for the microwave timer: buffers three BCD digits and serially loads them on START.
// Optional press debouncing is enabled by defining KEYPAD_LOADER_DEBOUNCE_EN.
module keypad_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic          clk,
  input logic          clr,
  keypad_loader_if.slave kp
);

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_T, LOAD_O, FIRE} state_t;

  state_t     state_reg;
  logic [3:0] mins_reg, tens_reg, ones_reg;
  logic [1:0] count_reg;
  logic [3:0] data_reg;
  logic       loadn_reg, clrn_reg, start_reg, error_reg, busy_reg;
  logic       accept;

`ifdef KEYPAD_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             lockout_reg;

  // A press whose key is seen while the loader is not idle is dropped until the key is released.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg     <= '0;
      lockout_reg <= 1'b0;
    end else if (!kp.key_valid) begin
      cnt_reg     <= '0;
      lockout_reg <= 1'b0;
    end else begin
      if (cnt_reg != CNT_W'(DEBOUNCE_CYCLES))
        cnt_reg <= cnt_reg + 1'b1;
      if (state_reg != IDLE)
        lockout_reg <= 1'b1;
    end
  end

  assign accept = kp.key_valid && !lockout_reg && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
`else
  logic valid_prev_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) valid_prev_reg <= 1'b0;
    else     valid_prev_reg <= kp.key_valid;
  end

  // A zero debounce setting disables keypad input in both builds.
  assign accept = kp.key_valid && !valid_prev_reg && (DEBOUNCE_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
      mins_reg  <= '0;
      tens_reg  <= '0;
      ones_reg  <= '0;
      count_reg <= '0;
      data_reg  <= '0;
      loadn_reg <= 1'b1;
      clrn_reg  <= 1'b1;
      start_reg <= 1'b0;
      error_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      clrn_reg  <= 1'b1;
      start_reg <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (kp.key_code <= 4'd9) begin
              mins_reg <= tens_reg;
              tens_reg <= ones_reg;
              ones_reg <= kp.key_code;
              if (count_reg != 2'd3)
                count_reg <= count_reg + 2'd1;
            end else if (kp.key_code == 4'hA) begin
              if (count_reg == 2'd0 || tens_reg > 4'd5) begin
                error_reg <= 1'b1;
              end else begin
                state_reg <= LOAD_M;
                data_reg  <= mins_reg;
                loadn_reg <= 1'b0;
                busy_reg  <= 1'b1;
              end
            end else if (kp.key_code == 4'hB) begin
              mins_reg  <= '0;
              tens_reg  <= '0;
              ones_reg  <= '0;
              count_reg <= '0;
              clrn_reg  <= 1'b0;
            end
          end
        end
        // The timer shifts ones->tens->mins per strobe, so mins goes out first.
        LOAD_M: begin
          state_reg <= LOAD_T;
          data_reg  <= tens_reg;
        end
        LOAD_T: begin
          state_reg <= LOAD_O;
          data_reg  <= ones_reg;
        end
        LOAD_O: begin
          state_reg <= FIRE;
          loadn_reg <= 1'b1;
          busy_reg  <= 1'b0;
          start_reg <= 1'b1;
        end
        FIRE: begin
          state_reg <= IDLE;
          mins_reg  <= '0;
          tens_reg  <= '0;
          ones_reg  <= '0;
          count_reg <= '0;
        end
        default: begin
          state_reg <= IDLE;
          loadn_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign kp.data        = data_reg;
  assign kp.loadn       = loadn_reg;
  assign kp.timer_clrn  = clrn_reg;
  assign kp.start       = start_reg;
  assign kp.error       = error_reg;
  assign kp.busy        = busy_reg;
  assign kp.entry_mins  = mins_reg;
  assign kp.entry_tens  = tens_reg;
  assign kp.entry_ones  = ones_reg;
  assign kp.digit_count = count_reg;

endmodule

// File: tb/tb_keypad_loader.sv
// Scoreboard bench for keypad_loader: stimulus queues expected timer events, a negedge monitor checks them.
module tb_keypad_loader;

  localparam int EV_LOAD  = 0;
  localparam int EV_START = 1;
  localparam int EV_ERROR = 2;
  localparam int EV_CLEAR = 3;

`ifdef KEYPAD_LOADER_DEBOUNCE_EN
  localparam int ACC = 4;
`else
  localparam int ACC = 1;
`endif

  typedef struct {
    int kind;
    int value;
  } ev_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  keypad_loader_if kp ();

  keypad_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .clr (clr),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  n_vec    = 0;
  int  n_fail   = 0;
  int  busy_cnt = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s = %0d", name, actual);
    end
  endtask

  task automatic check_event(input int kind, input int value);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind %0d value %0d, expected none", kind, value);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.value != value) begin
        n_fail++;
        $display("FAIL event: got kind %0d value %0d, expected kind %0d value %0d",
                 kind, value, e.kind, e.value);
      end else begin
        $display("ok   event kind %0d value %0d at %0t", kind, value, $time);
      end
    end
  endtask

  task automatic expect_ev(input int kind, input int value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  // Monitor: every timer-facing event is popped against the scoreboard.
  always @(negedge clk) begin
    if (!clr) begin
      if (kp.busy)        busy_cnt++;
      if (!kp.loadn)      check_event(EV_LOAD, int'(kp.data));
      if (kp.start)       check_event(EV_START, 0);
      if (kp.error)       check_event(EV_ERROR, 0);
      if (!kp.timer_clrn) check_event(EV_CLEAR, 0);
    end
  end

  task automatic press(input logic [3:0] code, input int hold, input int gap);
    @(posedge clk);
    #1;
    kp.key_code  = code;
    kp.key_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    kp.key_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic check_entry(input string tag, input int m, input int t, input int o, input int c);
    @(negedge clk);
    check({tag, ".mins"},  int'(kp.entry_mins), m);
    check({tag, ".tens"},  int'(kp.entry_tens), t);
    check({tag, ".ones"},  int'(kp.entry_ones), o);
    check({tag, ".count"}, int'(kp.digit_count), c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    kp.key_code  = 4'h0;
    kp.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.loadn", int'(kp.loadn), 1);
    check("rst.timer_clrn", int'(kp.timer_clrn), 1);
    check("rst.start", int'(kp.start), 0);
    check("rst.error", int'(kp.error), 0);
    check("rst.busy", int'(kp.busy), 0);
    check("rst.data", int'(kp.data), 0);
    check_entry("rst", 0, 0, 0, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (2) @(posedge clk);

    // 1,3,0 then START
    press(4'd1, 6, 6);
    press(4'd3, 6, 6);
    press(4'd0, 6, 6);
    check_entry("e130", 1, 3, 0, 3);
    expect_ev(EV_LOAD, 1);
    expect_ev(EV_LOAD, 3);
    expect_ev(EV_LOAD, 0);
    expect_ev(EV_START, 0);
    busy_cnt = 0;
    press(4'hA, 6, 6);
    check("s130.busy_cycles", busy_cnt, 3);
    check_entry("s130", 0, 0, 0, 0);

    // 2,5 then START: mins is zero-padded
    press(4'd2, 6, 6);
    press(4'd5, 6, 6);
    expect_ev(EV_LOAD, 0);
    expect_ev(EV_LOAD, 2);
    expect_ev(EV_LOAD, 5);
    expect_ev(EV_START, 0);
    busy_cnt = 0;
    press(4'hA, 6, 6);
    check("s25.busy_cycles", busy_cnt, 3);
    check("s25.data_hold", int'(kp.data), 5);
    check_entry("s25", 0, 0, 0, 0);

    // 9,9 then START: tens > 5 is rejected
    press(4'd9, 6, 6);
    press(4'd9, 6, 6);
    expect_ev(EV_ERROR, 0);
    press(4'hA, 6, 6);
    check_entry("e99", 0, 9, 9, 2);

    // 1,2,3,4 overflows the oldest digits, then CLEAR
    press(4'd1, 6, 6);
    press(4'd2, 6, 6);
    press(4'd3, 6, 6);
    press(4'd4, 6, 6);
    check_entry("e1234", 2, 3, 4, 3);
    expect_ev(EV_CLEAR, 0);
    press(4'hB, 6, 6);
    check_entry("clear", 0, 0, 0, 0);

    // START on empty entry
    expect_ev(EV_ERROR, 0);
    press(4'hA, 6, 6);
    check_entry("empty", 0, 0, 0, 0);

    // long hold counts once; ignored code has no effect
    press(4'd7, 10, 6);
    check_entry("hold7", 0, 0, 7, 1);
    press(4'hC, 6, 6);
    check_entry("codeC", 0, 0, 7, 1);

    // press that rises during LOAD_T is ignored
    expect_ev(EV_LOAD, 0);
    expect_ev(EV_LOAD, 0);
    expect_ev(EV_LOAD, 7);
    expect_ev(EV_START, 0);
    busy_cnt = 0;
    press(4'hA, ACC, 0);
    press(4'd8, 8, 8);
    check("s7.busy_cycles", busy_cnt, 3);
    check_entry("midload", 0, 0, 0, 0);

    // 2-cycle glitch
    press(4'd5, 2, 8);
`ifdef KEYPAD_LOADER_DEBOUNCE_EN
    check_entry("glitch", 0, 0, 0, 0);
`else
    check_entry("glitch", 0, 0, 5, 1);
`endif
    expect_ev(EV_CLEAR, 0);
    press(4'hB, 6, 6);
    check_entry("clear2", 0, 0, 0, 0);

    // reset during LOAD_T: no start pulse follows
    press(4'd4, 6, 6);
    press(4'd2, 6, 6);
    expect_ev(EV_LOAD, 0);
    press(4'hA, ACC, 0);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    check("rstmid.loadn", int'(kp.loadn), 1);
    check("rstmid.busy", int'(kp.busy), 0);
    check("rstmid.data", int'(kp.data), 0);
    check("rstmid.count", int'(kp.digit_count), 0);
    check("rstmid.tens", int'(kp.entry_tens), 0);
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (10) @(posedge clk);

    check("scoreboard.pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
